ppdu_symbol_framer: RTL and testbench

// - Transmit-side framer directly upstream of the symbol-to-chip spreader.
// - Builds the IEEE 802.15.4 O-QPSK PPDU: preamble (4 zero bytes), SFD, PHR (length), then PSDU bytes from the MAC.
// - Splits each byte into two 4-bit symbols, low nibble first.
// - Issues one symbol per spreader period, paced by the spreader's o_read strobe.

---
 rtl/zigbee_pkg.sv | 23 ++
 rtl/byte_nibble_buffer.sv | 50 +++++
 rtl/ppdu_symbol_framer.sv | 202 ++++++++++++++++++++
 tb/tb_ppdu_symbol_framer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zigbee_pkg.sv
// Shared constants and types for the IEEE 802.15.4 O-QPSK transmit/receive path.
package zigbee_pkg;

  localparam int unsigned SYMBOL_WIDTH   = 4;
  localparam int unsigned PREAMBLE_BYTES = 4;
  localparam logic [7:0]  SFD_VALUE      = 8'hA7;
  localparam int unsigned MAX_PSDU_LEN   = 127;
  localparam int unsigned LEN_WIDTH      = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_PHR,
    ST_PSDU,
    ST_DONE
  } framer_state_e;

  function automatic logic [3:0] nibble_of(input logic [7:0] b, input logic hi);
    return hi ? b[7:4] : b[3:0];
  endfunction

endpackage

// File: rtl/byte_nibble_buffer.sv
// One-byte prefetch register with valid/ready load, pop, and low/high nibble select.
module byte_nibble_buffer
  import zigbee_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic       i_accept_en,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  output logic       o_byte_ready,
  input  logic       i_pop,
  input  logic       i_nib_sel,
  output logic       o_full,
  output logic [3:0] o_nibble
);

  logic [7:0] byte_q, byte_d;
  logic       full_q, full_d;

  assign o_byte_ready = i_accept_en & ~full_q;
  assign o_full       = full_q;
  assign o_nibble     = nibble_of(byte_q, i_nib_sel);

  // Load only happens while empty and pop only while full, so they never collide.
  always_comb begin
    byte_d = byte_q;
    full_d = full_q;
    if (i_clear) begin
      byte_d = '0;
      full_d = 1'b0;
    end else if (i_byte_valid && o_byte_ready) begin
      byte_d = i_byte;
      full_d = 1'b1;
    end else if (i_pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      byte_q <= '0;
      full_q <= 1'b0;
    end else begin
      byte_q <= byte_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/ppdu_symbol_framer.sv
// Transmit PPDU framer: preamble, SFD, PHR and PSDU bytes split into symbols,
// one symbol per spreader period paced by i_read.
module ppdu_symbol_framer #(
  parameter int unsigned SYMBOL_WIDTH   = zigbee_pkg::SYMBOL_WIDTH,
  parameter int unsigned PREAMBLE_BYTES = zigbee_pkg::PREAMBLE_BYTES,
  parameter logic [7:0]  SFD_VALUE      = zigbee_pkg::SFD_VALUE,
  parameter int unsigned LEN_WIDTH      = zigbee_pkg::LEN_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [LEN_WIDTH-1:0]    i_length,
  input  logic [7:0]              i_byte,
  input  logic                    i_byte_valid,
  output logic                    o_byte_ready,
  output logic [SYMBOL_WIDTH-1:0] o_symbol,
  output logic                    o_symbol_valid,
  input  logic                    i_read,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_underrun
);
  import zigbee_pkg::*;

  framer_state_e         state_q, state_d;
  logic                  nib_q, nib_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;
  logic [LEN_WIDTH-1:0]  fetch_cnt_q, fetch_cnt_d;
  logic [SYMBOL_WIDTH-1:0] sym_q, sym_d;
  logic                  sym_valid_q, sym_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  underrun_q, underrun_d;
  logic                  armed_q, armed_d;

  logic       buf_clear, buf_pop, buf_sel, buf_full, buf_accept_en;
  logic [3:0] buf_nib;
  logic [7:0] phr;

  assign phr           = 8'(len_q);
  assign buf_accept_en = ((state_q == ST_PHR) || (state_q == ST_PSDU)) && (fetch_cnt_q < len_q);
  assign buf_sel       = (state_q == ST_PSDU) && !nib_q;

  byte_nibble_buffer u_buf (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (buf_clear),
    .i_accept_en  (buf_accept_en),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .i_pop        (buf_pop),
    .i_nib_sel    (buf_sel),
    .o_full       (buf_full),
    .o_nibble     (buf_nib)
  );

  // state_q/nib_q name the symbol last issued; each i_read issues the next one.
  always_comb begin
    state_d     = state_q;
    nib_d       = nib_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    fetch_cnt_d = fetch_cnt_q + LEN_WIDTH'(i_byte_valid && o_byte_ready);
    sym_d       = sym_q;
    sym_valid_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    underrun_d  = 1'b0;
    armed_d     = 1'b1;
    buf_clear   = 1'b0;
    buf_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start && armed_q) begin
          state_d     = ST_PREAMBLE;
          len_d       = i_length;
          busy_d      = 1'b1;
          sym_valid_d = 1'b1;
          sym_d       = '0;
          nib_d       = 1'b0;
          byte_cnt_d  = '0;
          fetch_cnt_d = '0;
          buf_clear   = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        if (i_read) begin
          sym_valid_d = 1'b1;
          nib_d       = ~nib_q;
          if (!nib_q) begin
            sym_d = '0;
          end else if (byte_cnt_q == LEN_WIDTH'(PREAMBLE_BYTES - 1)) begin
            state_d = ST_SFD;
            sym_d   = SYMBOL_WIDTH'(nibble_of(SFD_VALUE, 1'b0));
          end else begin
            byte_cnt_d = byte_cnt_q + LEN_WIDTH'(1);
            sym_d      = '0;
          end
        end
      end
      ST_SFD: begin
        if (i_read) begin
          sym_valid_d = 1'b1;
          nib_d       = ~nib_q;
          if (!nib_q) begin
            sym_d = SYMBOL_WIDTH'(nibble_of(SFD_VALUE, 1'b1));
          end else begin
            state_d = ST_PHR;
            sym_d   = SYMBOL_WIDTH'(nibble_of(phr, 1'b0));
          end
        end
      end
      ST_PHR: begin
        if (i_read) begin
          if (!nib_q) begin
            sym_valid_d = 1'b1;
            sym_d       = SYMBOL_WIDTH'(nibble_of(phr, 1'b1));
            nib_d       = 1'b1;
          end else if (len_q == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (buf_full) begin
            sym_valid_d = 1'b1;
            sym_d       = SYMBOL_WIDTH'(buf_nib);
            state_d     = ST_PSDU;
            nib_d       = 1'b0;
            byte_cnt_d  = '0;
          end else begin
            state_d    = ST_IDLE;
            underrun_d = 1'b1;
            busy_d     = 1'b0;
            buf_clear  = 1'b1;
          end
        end
      end
      ST_PSDU: begin
        if (i_read) begin
          if (!nib_q) begin
            sym_valid_d = 1'b1;
            sym_d       = SYMBOL_WIDTH'(buf_nib);
            nib_d       = 1'b1;
            buf_pop     = 1'b1;
          end else if (byte_cnt_q == len_q - LEN_WIDTH'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (buf_full) begin
            sym_valid_d = 1'b1;
            sym_d       = SYMBOL_WIDTH'(buf_nib);
            nib_d       = 1'b0;
            byte_cnt_d  = byte_cnt_q + LEN_WIDTH'(1);
          end else begin
            state_d    = ST_IDLE;
            underrun_d = 1'b1;
            busy_d     = 1'b0;
            buf_clear  = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      nib_q       <= 1'b0;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      fetch_cnt_q <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      nib_q       <= nib_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      armed_q     <= armed_d;
    end
  end

  assign o_symbol       = sym_q;
  assign o_symbol_valid = sym_valid_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_underrun     = underrun_q;

endmodule

// File: tb/tb_ppdu_symbol_framer.sv
// Directed bench for ppdu_symbol_framer with a 32-cycle spreader pacing model.
module tb_ppdu_symbol_framer;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [6:0] i_length = '0;
  logic [7:0] i_byte = '0;
  logic       i_byte_valid = 1'b0;
  logic       o_byte_ready;
  logic [3:0] o_symbol;
  logic       o_symbol_valid;
  logic       i_read;
  logic       o_busy;
  logic       o_done;
  logic       o_underrun;

  always #5 i_clk = ~i_clk;

  ppdu_symbol_framer #(
    .SYMBOL_WIDTH   (4),
    .PREAMBLE_BYTES (4),
    .SFD_VALUE      (8'hA7),
    .LEN_WIDTH      (7)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (i_start),
    .i_length       (i_length),
    .i_byte         (i_byte),
    .i_byte_valid   (i_byte_valid),
    .o_byte_ready   (o_byte_ready),
    .o_symbol       (o_symbol),
    .o_symbol_valid (o_symbol_valid),
    .i_read         (i_read),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_underrun     (o_underrun)
  );

  // Spreader model: a symbol occupies 32 chip cycles; the read strobe lands so
  // that the framer's registered pulse arrives on the final chip cycle.
  logic       sp_active;
  logic [4:0] sp_cnt;
  logic       rd_force = 1'b0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sp_active <= 1'b0;
      sp_cnt    <= '0;
    end else if (o_symbol_valid) begin
      sp_active <= 1'b1;
      sp_cnt    <= '0;
    end else if (sp_active) begin
      if (sp_cnt == 5'd31) sp_active <= 1'b0;
      else                 sp_cnt    <= sp_cnt + 5'd1;
    end
  end

  assign i_read = (sp_active && sp_cnt == 5'd30) || rd_force;

  logic [3:0] sym_q[$];
  logic [3:0] exp_q[$];
  int done_cnt, under_cnt, xfer_cnt, pace_err, chip_cnt, first_chip, last_chip, cyc;
  logic read_d = 1'b0, start_d = 1'b0, under_busy = 1'b0;

  always @(negedge i_clk) begin
    cyc++;
    if (i_rst_n) begin
      if (o_symbol_valid) begin
        sym_q.push_back(o_symbol);
        if (!(read_d || start_d) || i_read) pace_err++;
      end
      if (o_done) begin
        done_cnt++;
        if (!read_d) pace_err++;
      end
      if (o_underrun) begin
        under_cnt++;
        under_busy = o_busy;
      end
      if (i_byte_valid && o_byte_ready) xfer_cnt++;
      if (sp_active) begin
        if (first_chip < 0) first_chip = cyc;
        last_chip = cyc;
        chip_cnt++;
      end
    end
    read_d  = i_read;
    start_d = i_start && !o_busy;
  end

  logic [7:0] mac_bytes [0:127];
  int  mac_len = 0, mac_idx = 0, mac_hold = 1000;
  bit  mac_gaps = 1'b0;

  initial begin
    bit tk;
    forever begin
      @(negedge i_clk);
      tk = i_byte_valid && o_byte_ready;
      @(posedge i_clk);
      #1;
      if (tk) mac_idx++;
      i_byte_valid = (mac_idx < mac_len) && (mac_idx < mac_hold) &&
                     (!mac_gaps || $urandom_range(0, 3) != 0);
      i_byte = (mac_idx < 128) ? mac_bytes[mac_idx] : 8'h00;
    end
  end

  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    sym_q.delete();
    exp_q.delete();
    done_cnt = 0; under_cnt = 0; xfer_cnt = 0; pace_err = 0;
    chip_cnt = 0; first_chip = -1; last_chip = -1; under_busy = 1'b1;
  endtask

  task automatic push_hdr(input int len);
    for (int i = 0; i < 8; i++) exp_q.push_back(4'h0);
    exp_q.push_back(4'h7);
    exp_q.push_back(4'hA);
    exp_q.push_back(4'(len & 15));
    exp_q.push_back(4'(len >> 4));
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(b[3:0]);
    exp_q.push_back(b[7:4]);
  endtask

  task automatic pulse_start(input int len);
    i_length = 7'(len);
    @(posedge i_clk); #1 i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
  endtask

  task automatic run_frame(input int len, input int hold, input bit gaps);
    mac_len = len; mac_idx = 0; mac_hold = hold; mac_gaps = gaps;
    pulse_start(len);
    for (int c = 0; c < 32 * (12 + 2 * len) + 100; c++) begin
      if (done_cnt + under_cnt != 0) break;
      @(negedge i_clk);
    end
    repeat (40) @(negedge i_clk);
  endtask

  task automatic check_frame(input string tag, input int exp_done, input int exp_under,
                             input int exp_xfer);
    check({tag, "_sym_count"}, sym_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sym_q.size(); i++)
      check($sformatf("%s_sym%0d", tag, i), sym_q[i], exp_q[i]);
    check({tag, "_done"}, done_cnt, exp_done);
    check({tag, "_underrun"}, under_cnt, exp_under);
    check({tag, "_xfers"}, xfer_cnt, exp_xfer);
    check({tag, "_pacing"}, pace_err, 0);
    check({tag, "_busy_end"}, o_busy, 0);
    if (exp_done == 1) begin
      check({tag, "_chips"}, chip_cnt, 32 * exp_q.size());
      check({tag, "_chip_gap"}, last_chip - first_chip + 1, chip_cnt);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_symbol"}, o_symbol, 0);
    check({tag, "_valid"}, o_symbol_valid, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_underrun"}, o_underrun, 0);
    check({tag, "_ready"}, o_byte_ready, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mon();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_idle_outputs("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Read strobes while idle must not start anything.
    rd_force = 1'b1;
    repeat (3) @(negedge i_clk);
    rd_force = 1'b0;
    repeat (3) @(negedge i_clk);
    check("idle_read_syms", sym_q.size(), 0);
    check("idle_read_busy", o_busy, 0);
    check("idle_read_done", done_cnt, 0);

    clear_mon();
    push_hdr(0);
    run_frame(0, 1000, 1'b0);
    check_frame("len0", 1, 0, 0);

    clear_mon();
    mac_bytes[0] = 8'h3C; mac_bytes[1] = 8'hF1;
    push_hdr(2); push_byte(8'h3C); push_byte(8'hF1);
    run_frame(2, 1000, 1'b0);
    check_frame("len2", 1, 0, 2);

    clear_mon();
    push_hdr(127);
    for (int i = 0; i < 127; i++) begin
      mac_bytes[i] = 8'((i * 37 + 11) & 255);
      push_byte(mac_bytes[i]);
    end
    run_frame(127, 1000, 1'b1);
    check_frame("len127", 1, 0, 127);

    clear_mon();
    mac_bytes[0] = 8'h11; mac_bytes[1] = 8'h22; mac_bytes[2] = 8'h33;
    push_hdr(3); push_byte(8'h11);
    run_frame(3, 1, 1'b0);
    check_frame("underrun", 0, 1, 1);
    check("underrun_busy", under_busy, 0);

    // Frame interrupted by reset; an extra start mid-frame must be ignored.
    clear_mon();
    for (int i = 0; i < 5; i++) mac_bytes[i] = 8'(i + 1);
    mac_len = 5; mac_idx = 0; mac_hold = 1000; mac_gaps = 1'b0;
    pulse_start(5);
    for (int c = 0; c < 300 && sym_q.size() < 3; c++) @(negedge i_clk);
    pulse_start(9);
    for (int c = 0; c < 32 * 20 + 100 && sym_q.size() < 20; c++) @(negedge i_clk);
    check("rst_sym20_reached", sym_q.size(), 20);
    check("rst_phr_lo", sym_q.size() > 10 ? int'(sym_q[10]) : -1, 5);
    check("rst_phr_hi", sym_q.size() > 11 ? int'(sym_q[11]) : -1, 0);
    check("rst_pacing", pace_err, 0);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    check_idle_outputs("midreset");
    check("midreset_no_done", done_cnt, 0);
    i_length = 7'd1;
    i_start  = 1'b1;
    i_rst_n  = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    @(negedge i_clk);
    check("start_at_release_busy", o_busy, 0);
    check("start_at_release_valid", o_symbol_valid, 0);
    repeat (5) @(negedge i_clk);

    clear_mon();
    mac_bytes[0] = 8'h5A;
    push_hdr(1); push_byte(8'h5A);
    run_frame(1, 1000, 1'b0);
    check_frame("after_reset", 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
